// File: rtl/spare_sram_ctrl.sv
// spare_sram_ctrl
//
// Repair controller for the 4-bank, 1024x8 spare SRAM of the BISR memory
// controller. BIST loads faulty main-array word addresses into a small
// repair table. Each access is looked up in that table:
//   - a hit is served by the spare word for that entry;
//   - a miss is answered with RSP_HIT=0 so the main array serves the access.
// This block is the only driver of the spare SRAM pins.
//
// Table entry k lives in spare bank k[1:0] at word k>>2.
//
// Optional feature macro: SPARE_CTRL_INIT_EN
//   When defined, every newly allocated entry has its spare word cleared to
//   8'h00 before ALLOC_DONE is pulsed.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   ALLOC_VALID/ADDR    BIST reports a faulty address (one-cycle pulse)
//   ALLOC_DONE          one-cycle pulse: allocation finished or rejected
//   ALLOC_FULL          sticky: table was full and a request was dropped
//   REPAIR_CNT          number of valid table entries
//   REQ/REQ_WE/REQ_ADDR/REQ_WDATA/REQ_READY   access request channel
//   RSP_VALID/RSP_HIT/RSP_RDATA               one-cycle response
//   MEM_*               spare SRAM pins (WEB, OEB, CSB active-low)
//   dbg_state           current FSM state
//
// Handshake: a request is transferred on a rising edge where REQ and
// REQ_READY are both 1. REQ_READY is only high while idle and drops in the
// same cycle ALLOC_VALID is high, because allocation takes priority.
module spare_sram_ctrl #(
   parameter int ADDR_W      = 12,
   parameter int NUM_ENTRIES = 16,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ALLOC_VALID,
   input  logic [ADDR_W-1:0] ALLOC_ADDR,
   output logic              ALLOC_DONE,
   output logic              ALLOC_FULL,
   output logic [IDX_W:0]    REPAIR_CNT,
   input  logic              REQ,
   input  logic              REQ_WE,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [7:0]        REQ_WDATA,
   output logic              REQ_READY,
   output logic              RSP_VALID,
   output logic              RSP_HIT,
   output logic [7:0]        RSP_RDATA,
   output logic [9:0]        MEM_ADDR,
   output logic              MEM_CE,
   output logic              MEM_WEB,
   output logic [3:0]        MEM_OEB,
   output logic [3:0]        MEM_CSB,
   output logic [7:0]        MEM_IDATA,
   input  logic [7:0]        MEM_ODATA,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOOKUP, ST_SETUP, ST_STROBE, ST_CAPTURE, ST_DONE, ST_ALLOC
   } state_t;

   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(NUM_ENTRIES);

   state_t                   state_q, state_d;
   logic                     we_q, we_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [7:0]               wdata_q, wdata_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     hit_q, hit_d;
   logic                     init_q, init_d;
   logic [ADDR_W-1:0]        tbl_q [NUM_ENTRIES];
   logic [ADDR_W-1:0]        tbl_d [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0]   vld_q, vld_d;
   logic [IDX_W:0]           cnt_q, cnt_d;
   logic                     full_q, full_d;
   logic                     done_q, done_d;
   logic                     rdy_q, rdy_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic                     rsp_hit_q, rsp_hit_d;
   logic [7:0]               rsp_rdata_q, rsp_rdata_d;
   logic [9:0]               mem_addr_q, mem_addr_d;
   logic                     mem_ce_q, mem_ce_d;
   logic                     mem_web_q, mem_web_d;
   logic [3:0]               mem_oeb_q, mem_oeb_d;
   logic [3:0]               mem_csb_q, mem_csb_d;
   logic [7:0]               mem_idata_q, mem_idata_d;

   logic                     match;
   logic [IDX_W-1:0]         match_idx;
   logic                     active;
   logic [11:0]              idx_ext;
   logic [3:0]               sel_n;

   // Compare the latched address with every valid entry. The table never
   // holds duplicates, so at most one entry can match.
   always_comb begin
      match     = 1'b0;
      match_idx = '0;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
         if (vld_q[k] && (tbl_q[k] == addr_q)) begin
            match     = 1'b1;
            match_idx = IDX_W'(k);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      idx_d       = idx_q;
      hit_d       = hit_q;
      init_d      = init_q;
      tbl_d       = tbl_q;
      vld_d       = vld_q;
      cnt_d       = cnt_q;
      full_d      = full_q;
      done_d      = 1'b0;
      rsp_rdata_d = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (ALLOC_VALID) begin
               addr_d  = ALLOC_ADDR;
               state_d = ST_ALLOC;
            end else if (REQ) begin
               we_d    = REQ_WE;
               addr_d  = REQ_ADDR;
               wdata_d = REQ_WDATA;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            hit_d   = match;
            idx_d   = match_idx;
            state_d = match ? ST_SETUP : ST_DONE;
         end
         ST_SETUP:  state_d = ST_STROBE;
         ST_STROBE: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            if (init_q) begin
               // Clearing a freshly allocated spare word: no response.
               init_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               if (!we_q) rsp_rdata_d = MEM_ODATA;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ALLOC: begin
            if (match) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == FULL_CNT) begin
               full_d  = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tbl_d[cnt_q[IDX_W-1:0]] = addr_q;
               vld_d[cnt_q[IDX_W-1:0]] = 1'b1;
               cnt_d                   = cnt_q + 1'b1;
`ifdef SPARE_CTRL_INIT_EN
               idx_d   = cnt_q[IDX_W-1:0];
               we_d    = 1'b1;
               wdata_d = 8'h00;
               init_d  = 1'b1;
               state_d = ST_SETUP;
`else
               done_d  = 1'b1;
               state_d = ST_IDLE;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pin values are derived from the next state so they are registered
      // and line up with the state they belong to.
      active  = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                (state_d == ST_CAPTURE);
      idx_ext = 12'(idx_d);
      sel_n   = ~(4'b0001 << idx_ext[1:0]);

      mem_csb_d   = active ? sel_n : 4'hF;
      mem_ce_d    = (state_d == ST_STROBE);
      mem_oeb_d   = (((state_d == ST_STROBE) || (state_d == ST_CAPTURE)) && !we_d)
                    ? sel_n : 4'hF;
      mem_web_d   = active ? ~we_d : 1'b1;
      mem_addr_d  = active ? idx_ext[11:2] : mem_addr_q;
      mem_idata_d = active ? wdata_d : mem_idata_q;
      rdy_d       = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_DONE);
      rsp_hit_d   = (state_d == ST_DONE) && hit_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 8'h00;
         idx_q       <= '0;
         hit_q       <= 1'b0;
         init_q      <= 1'b0;
         tbl_q       <= '{default: '0};
         vld_q       <= '0;
         cnt_q       <= '0;
         full_q      <= 1'b0;
         done_q      <= 1'b0;
         rdy_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_rdata_q <= 8'h00;
         mem_addr_q  <= 10'h000;
         mem_ce_q    <= 1'b0;
         mem_web_q   <= 1'b1;
         mem_oeb_q   <= 4'hF;
         mem_csb_q   <= 4'hF;
         mem_idata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         idx_q       <= idx_d;
         hit_q       <= hit_d;
         init_q      <= init_d;
         tbl_q       <= tbl_d;
         vld_q       <= vld_d;
         cnt_q       <= cnt_d;
         full_q      <= full_d;
         done_q      <= done_d;
         rdy_q       <= rdy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_ce_q    <= mem_ce_d;
         mem_web_q   <= mem_web_d;
         mem_oeb_q   <= mem_oeb_d;
         mem_csb_q   <= mem_csb_d;
         mem_idata_q <= mem_idata_d;
      end
   end

   assign ALLOC_DONE = done_q;
   assign ALLOC_FULL = full_q;
   assign REPAIR_CNT = cnt_q;
   assign REQ_READY  = rdy_q & ~ALLOC_VALID;
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_HIT    = rsp_hit_q;
   assign RSP_RDATA  = rsp_rdata_q;
   assign MEM_ADDR   = mem_addr_q;
   assign MEM_CE     = mem_ce_q;
   assign MEM_WEB    = mem_web_q;
   assign MEM_OEB    = mem_oeb_q;
   assign MEM_CSB    = mem_csb_q;
   assign MEM_IDATA  = mem_idata_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_spare_sram_ctrl.sv
// Testbench for spare_sram_ctrl: directed scenarios with hand-computed
// expectations, plus a behavioural 4-bank spare SRAM answering MEM_*.
module tb_spare_sram_ctrl;

   logic        clk = 1'b0;
   logic        RST, ALLOC_VALID, REQ, REQ_WE;
   logic [11:0] ALLOC_ADDR, REQ_ADDR;
   logic [7:0]  REQ_WDATA, MEM_ODATA, RSP_RDATA, MEM_IDATA;
   logic        ALLOC_DONE, ALLOC_FULL, REQ_READY, RSP_VALID, RSP_HIT;
   logic [4:0]  REPAIR_CNT;
   logic [9:0]  MEM_ADDR;
   logic        MEM_CE, MEM_WEB;
   logic [3:0]  MEM_OEB, MEM_CSB;
   logic [2:0]  dbg_state;

   int n_total = 0;
   int n_bad   = 0;

`ifdef SPARE_CTRL_INIT_EN
   localparam int         NEW_LAT    = 5;
   localparam logic [7:0] PRIO_RDATA = 8'h00;
`else
   localparam int         NEW_LAT    = 2;
   localparam logic [7:0] PRIO_RDATA = 8'hC3;
`endif

   always #5 clk = ~clk;

   spare_sram_ctrl dut (
      .CLK(clk), .RST(RST),
      .ALLOC_VALID(ALLOC_VALID), .ALLOC_ADDR(ALLOC_ADDR),
      .ALLOC_DONE(ALLOC_DONE), .ALLOC_FULL(ALLOC_FULL), .REPAIR_CNT(REPAIR_CNT),
      .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_HIT(RSP_HIT),
      .RSP_RDATA(RSP_RDATA), .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE),
      .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB), .MEM_CSB(MEM_CSB),
      .MEM_IDATA(MEM_IDATA), .MEM_ODATA(MEM_ODATA), .dbg_state(dbg_state)
   );

   // Spare SRAM model: write on a strobed edge, ORed bank read outputs.
   logic [7:0] smem [4][1024];
   initial begin
      for (int b = 0; b < 4; b++)
         for (int w = 0; w < 1024; w++) smem[b][w] = 8'hA7;
   end
   always @(posedge clk) begin
      if (MEM_CE && !MEM_WEB)
         for (int b = 0; b < 4; b++)
            if (!MEM_CSB[b]) smem[b][MEM_ADDR] <= MEM_IDATA;
   end
   always @* begin
      MEM_ODATA = 8'h00;
      for (int b = 0; b < 4; b++)
         if (!MEM_CSB[b] && !MEM_OEB[b]) MEM_ODATA = MEM_ODATA | smem[b][MEM_ADDR];
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; REQ = 1'b0; ALLOC_VALID = 1'b0;
      repeat (3) step();
      RST = 1'b0;
   endtask

   // Observations recorded by run_access (cycle 0 = accept edge).
   int         r_rsp_cyc, r_rsp_n, r_rdy_cyc, r_ce_n, r_ce_cyc, r_oeb_n, r_sel_n;
   logic       r_hit, r_ce_web;
   logic [7:0] r_rdata, r_ce_idata;
   logic [3:0] r_ce_csb;
   logic [9:0] r_ce_addr;
   int         a_lat;

   task automatic run_access(input logic we, input logic [11:0] a, input logic [7:0] d);
      int w;
      r_rsp_cyc = 0; r_rsp_n = 0; r_rdy_cyc = 0; r_ce_n = 0; r_ce_cyc = 0;
      r_oeb_n = 0; r_sel_n = 0; r_hit = 1'bx; r_rdata = 8'hxx;
      r_ce_web = 1'bx; r_ce_idata = 8'hxx; r_ce_csb = 4'hx; r_ce_addr = 10'hxxx;
      w = 0;
      while (!REQ_READY && w < 20) begin step(); w++; end
      if (!REQ_READY) return;
      REQ = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = d;
      step();
      REQ = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (MEM_CE) begin
            r_ce_n++; r_ce_cyc = cyc; r_ce_csb = MEM_CSB; r_ce_addr = MEM_ADDR;
            r_ce_web = MEM_WEB; r_ce_idata = MEM_IDATA;
         end
         if (MEM_OEB !== 4'hF) r_oeb_n++;
         if (MEM_CSB !== 4'hF) r_sel_n++;
         if (RSP_VALID) begin
            r_rsp_n++;
            if (r_rsp_cyc == 0) begin r_rsp_cyc = cyc; r_hit = RSP_HIT; r_rdata = RSP_RDATA; end
         end
         if (REQ_READY && r_rsp_n > 0) begin r_rdy_cyc = cyc; break; end
         step();
      end
   endtask

   task automatic run_alloc(input logic [11:0] a);
      int w;
      a_lat = 0;
      w = 0;
      while (!REQ_READY && w < 20) begin step(); w++; end
      ALLOC_VALID = 1'b1; ALLOC_ADDR = a;
      step();
      ALLOC_VALID = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (ALLOC_DONE) begin a_lat = cyc; break; end
         step();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      n_total++; if (REQ_READY !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", REQ_READY); end
      n_total++; if (ALLOC_DONE !== 1'b0 || ALLOC_FULL !== 1'b0) begin n_bad++; $display("FAIL rst_alloc_flags: got done=%b full=%b want 0 0", ALLOC_DONE, ALLOC_FULL); end
      n_total++; if (REPAIR_CNT !== 5'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", REPAIR_CNT); end
      n_total++; if (RSP_VALID !== 1'b0 || RSP_HIT !== 1'b0 || RSP_RDATA !== 8'h00) begin n_bad++; $display("FAIL rst_rsp: got v=%b h=%b d=%h want 0 0 00", RSP_VALID, RSP_HIT, RSP_RDATA); end
      n_total++; if (MEM_CE !== 1'b0 || MEM_WEB !== 1'b1 || MEM_OEB !== 4'hF || MEM_CSB !== 4'hF) begin n_bad++; $display("FAIL rst_mem_ctl: got ce=%b web=%b oeb=%h csb=%h want 0 1 f f", MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB); end
      n_total++; if (MEM_ADDR !== 10'd0 || MEM_IDATA !== 8'h00) begin n_bad++; $display("FAIL rst_mem_data: got addr=%h idata=%h want 0 00", MEM_ADDR, MEM_IDATA); end
      run_access(1'b0, 12'h0A5, 8'h00);
      n_total++; if (r_rsp_cyc !== 2 || r_hit !== 1'b0 || r_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_miss_rsp: got cyc=%0d hit=%b d=%h want 2 0 00", r_rsp_cyc, r_hit, r_rdata); end
      n_total++; if (r_sel_n !== 0 || r_ce_n !== 0 || r_rdy_cyc !== 3) begin n_bad++; $display("FAIL rst_miss_pins: got sel=%0d ce=%0d rdy=%0d want 0 0 3", r_sel_n, r_ce_n, r_rdy_cyc); end
   endtask

   task automatic test_write_read_hit();
      run_alloc(12'h123);
      n_total++; if (a_lat !== NEW_LAT || REPAIR_CNT !== 5'd1) begin n_bad++; $display("FAIL alloc_123: got lat=%0d cnt=%0d want %0d 1", a_lat, REPAIR_CNT, NEW_LAT); end
      run_alloc(12'h456);
      n_total++; if (a_lat !== NEW_LAT || REPAIR_CNT !== 5'd2) begin n_bad++; $display("FAIL alloc_456: got lat=%0d cnt=%0d want %0d 2", a_lat, REPAIR_CNT, NEW_LAT); end
      run_access(1'b1, 12'h456, 8'h5A);
      n_total++; if (r_ce_n !== 1 || r_ce_cyc !== 3) begin n_bad++; $display("FAIL wr456_strobe: got n=%0d cyc=%0d want 1 3", r_ce_n, r_ce_cyc); end
      n_total++; if (r_ce_csb !== 4'b1101 || r_ce_addr !== 10'd0 || r_ce_web !== 1'b0 || r_ce_idata !== 8'h5A) begin n_bad++; $display("FAIL wr456_pins: got csb=%b addr=%h web=%b d=%h want 1101 0 0 5a", r_ce_csb, r_ce_addr, r_ce_web, r_ce_idata); end
      n_total++; if (r_rsp_cyc !== 5 || r_hit !== 1'b1 || r_rdata !== 8'h00 || r_oeb_n !== 0 || r_rdy_cyc !== 6) begin n_bad++; $display("FAIL wr456_rsp: got cyc=%0d hit=%b d=%h oeb=%0d rdy=%0d want 5 1 00 0 6", r_rsp_cyc, r_hit, r_rdata, r_oeb_n, r_rdy_cyc); end
      run_access(1'b0, 12'h456, 8'h00);
      n_total++; if (r_rsp_cyc !== 5 || r_hit !== 1'b1 || r_rdata !== 8'h5A) begin n_bad++; $display("FAIL rd456: got cyc=%0d hit=%b d=%h want 5 1 5a", r_rsp_cyc, r_hit, r_rdata); end
      n_total++; if (r_oeb_n !== 2 || r_ce_web !== 1'b1 || r_rdy_cyc !== 6) begin n_bad++; $display("FAIL rd456_pins: got oeb=%0d web=%b rdy=%0d want 2 1 6", r_oeb_n, r_ce_web, r_rdy_cyc); end
      run_access(1'b1, 12'h123, 8'hC3);
      n_total++; if (r_ce_csb !== 4'b1110 || r_ce_addr !== 10'd0) begin n_bad++; $display("FAIL wr123_pins: got csb=%b addr=%h want 1110 0", r_ce_csb, r_ce_addr); end
      run_access(1'b0, 12'h123, 8'h00);
      n_total++; if (r_hit !== 1'b1 || r_rdata !== 8'hC3) begin n_bad++; $display("FAIL rd123: got hit=%b d=%h want 1 c3", r_hit, r_rdata); end
      run_access(1'b1, 12'h789, 8'h11);
      n_total++; if (r_rsp_cyc !== 2 || r_hit !== 1'b0 || r_ce_n !== 0 || r_sel_n !== 0) begin n_bad++; $display("FAIL wr789_miss: got cyc=%0d hit=%b ce=%0d sel=%0d want 2 0 0 0", r_rsp_cyc, r_hit, r_ce_n, r_sel_n); end
   endtask

   task automatic test_table_limits();
      run_alloc(12'h456);
      n_total++; if (a_lat !== 2 || REPAIR_CNT !== 5'd2 || ALLOC_FULL !== 1'b0) begin n_bad++; $display("FAIL dup_456: got lat=%0d cnt=%0d full=%b want 2 2 0", a_lat, REPAIR_CNT, ALLOC_FULL); end
      for (int i = 2; i < 16; i++) begin
         run_alloc(12'(12'h200 + i));
         n_total++; if (a_lat !== NEW_LAT || REPAIR_CNT !== 5'(i + 1) || ALLOC_FULL !== 1'b0) begin n_bad++; $display("FAIL fill_%0d: got lat=%0d cnt=%0d full=%b want %0d %0d 0", i, a_lat, REPAIR_CNT, ALLOC_FULL, NEW_LAT, i + 1); end
      end
      run_alloc(12'h300);
      n_total++; if (a_lat !== 2 || REPAIR_CNT !== 5'd16 || ALLOC_FULL !== 1'b1) begin n_bad++; $display("FAIL overflow: got lat=%0d cnt=%0d full=%b want 2 16 1", a_lat, REPAIR_CNT, ALLOC_FULL); end
      run_alloc(12'h123);
      n_total++; if (a_lat !== 2 || REPAIR_CNT !== 5'd16) begin n_bad++; $display("FAIL dup_full: got lat=%0d cnt=%0d want 2 16", a_lat, REPAIR_CNT); end
      run_access(1'b1, 12'h20E, 8'h99);
      n_total++; if (r_ce_csb !== 4'b1011 || r_ce_addr !== 10'd3 || r_hit !== 1'b1) begin n_bad++; $display("FAIL wr_e14: got csb=%b addr=%h hit=%b want 1011 3 1", r_ce_csb, r_ce_addr, r_hit); end
      run_access(1'b0, 12'h20E, 8'h00);
      n_total++; if (r_rdata !== 8'h99 || r_rsp_cyc !== 5) begin n_bad++; $display("FAIL rd_e14: got d=%h cyc=%0d want 99 5", r_rdata, r_rsp_cyc); end
      run_access(1'b0, 12'h300, 8'h00);
      n_total++; if (r_hit !== 1'b0 || r_rsp_cyc !== 2) begin n_bad++; $display("FAIL rd_dropped: got hit=%b cyc=%0d want 0 2", r_hit, r_rsp_cyc); end
   endtask

   task automatic test_priority();
      int   cyc;
      logic rdy_seen;
      do_reset();
      ALLOC_VALID = 1'b1; ALLOC_ADDR = 12'h0F0;
      REQ = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 12'h0F0; REQ_WDATA = 8'h00;
      #1;
      n_total++; if (REQ_READY !== 1'b0) begin n_bad++; $display("FAIL prio_ready_gate: got %b want 0", REQ_READY); end
      @(posedge clk); #1;
      ALLOC_VALID = 1'b0;
      cyc = 1; rdy_seen = 1'b0;
      while (!ALLOC_DONE && cyc < 10) begin
         if (REQ_READY) rdy_seen = 1'b1;
         step(); cyc++;
      end
      n_total++; if (rdy_seen !== 1'b0 || cyc !== NEW_LAT) begin n_bad++; $display("FAIL prio_alloc: got early_ready=%b lat=%0d want 0 %0d", rdy_seen, cyc, NEW_LAT); end
      n_total++; if (REQ_READY !== 1'b1 || REPAIR_CNT !== 5'd1) begin n_bad++; $display("FAIL prio_after_done: got ready=%b cnt=%0d want 1 1", REQ_READY, REPAIR_CNT); end
      step();
      REQ = 1'b0;
      cyc = 1;
      while (!RSP_VALID && cyc < 12) begin step(); cyc++; end
      n_total++; if (cyc !== 5 || RSP_HIT !== 1'b1 || RSP_RDATA !== PRIO_RDATA) begin n_bad++; $display("FAIL prio_req: got cyc=%0d hit=%b d=%h want 5 1 %h", cyc, RSP_HIT, RSP_RDATA, PRIO_RDATA); end
      cyc = 0;
      while (!REQ_READY && cyc < 10) begin step(); cyc++; end
   endtask

   task automatic test_reset_mid_access();
      int rsp_n;
      do_reset();
      run_alloc(12'h0AA);
      REQ = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 12'h0AA; REQ_WDATA = 8'hAA;
      step();
      REQ = 1'b0;
      step(); step();
      n_total++; if (MEM_CE !== 1'b1) begin n_bad++; $display("FAIL mid_in_strobe: got ce=%b want 1", MEM_CE); end
      RST = 1'b1;
      step();
      n_total++; if (REQ_READY !== 1'b1 || ALLOC_DONE !== 1'b0 || ALLOC_FULL !== 1'b0 || REPAIR_CNT !== 5'd0) begin n_bad++; $display("FAIL mid_rst_ctl: got rdy=%b done=%b full=%b cnt=%0d want 1 0 0 0", REQ_READY, ALLOC_DONE, ALLOC_FULL, REPAIR_CNT); end
      n_total++; if (RSP_VALID !== 1'b0 || RSP_HIT !== 1'b0 || RSP_RDATA !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rsp: got v=%b h=%b d=%h want 0 0 00", RSP_VALID, RSP_HIT, RSP_RDATA); end
      n_total++; if (MEM_CE !== 1'b0 || MEM_WEB !== 1'b1 || MEM_OEB !== 4'hF || MEM_CSB !== 4'hF || MEM_ADDR !== 10'd0 || MEM_IDATA !== 8'h00) begin n_bad++; $display("FAIL mid_rst_mem: got ce=%b web=%b oeb=%h csb=%h addr=%h d=%h want 0 1 f f 0 00", MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB, MEM_ADDR, MEM_IDATA); end
      RST = 1'b0;
      rsp_n = 0;
      repeat (6) begin if (RSP_VALID) rsp_n++; step(); end
      n_total++; if (rsp_n !== 0) begin n_bad++; $display("FAIL mid_no_rsp: got %0d responses want 0", rsp_n); end
      run_access(1'b0, 12'h0AA, 8'h00);
      n_total++; if (r_hit !== 1'b0 || r_rsp_cyc !== 2) begin n_bad++; $display("FAIL mid_table_cleared: got hit=%b cyc=%0d want 0 2", r_hit, r_rsp_cyc); end
   endtask

`ifdef SPARE_CTRL_INIT_EN
   task automatic test_init_en();
      do_reset();
      run_alloc(12'h111);
      n_total++; if (a_lat !== 5 || REPAIR_CNT !== 5'd1) begin n_bad++; $display("FAIL init_alloc: got lat=%0d cnt=%0d want 5 1", a_lat, REPAIR_CNT); end
      run_alloc(12'h111);
      n_total++; if (a_lat !== 2 || REPAIR_CNT !== 5'd1) begin n_bad++; $display("FAIL init_dup: got lat=%0d cnt=%0d want 2 1", a_lat, REPAIR_CNT); end
      run_access(1'b0, 12'h111, 8'h00);
      n_total++; if (r_hit !== 1'b1 || r_rdata !== 8'h00) begin n_bad++; $display("FAIL init_read: got hit=%b d=%h want 1 00", r_hit, r_rdata); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; ALLOC_VALID = 1'b0; ALLOC_ADDR = '0;
      REQ = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
      step();
      test_reset();
      test_write_read_hit();
      test_table_limits();
      test_priority();
      test_reset_mid_access();
`ifdef SPARE_CTRL_INIT_EN
      test_init_en();
`endif
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
